// File: rtl/sw_conditioner.sv
// Push-switch front end: synchroniser, per-switch debounce FSM, press pulse, long-press flag.
// Optional auto-repeat while long-pressed is enabled by defining SW_REPEAT_EN.
module sw_conditioner #(
  parameter int N_SW          = 5,
  parameter int SW_ACTIVE_LOW = 1,
  parameter int DEB_CNT       = 500000,
  parameter int LONG_CNT      = 50000000,
  parameter int REP_CNT       = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_sw_pulse,
  output logic [N_SW-1:0] o_sw_level,
  output logic [N_SW-1:0] o_sw_long
);

  localparam int DEB_W  = $clog2(DEB_CNT + 1);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0] LONG_SAT  = HOLD_W'(LONG_CNT);
  localparam logic [N_SW-1:0]   REL_LVL   = (SW_ACTIVE_LOW != 0) ? '1 : '0;

  // The early-exit compare on deb_q + 1 needs at least two debounce cycles.
  if (DEB_CNT < 2 || LONG_CNT < 1 || REP_CNT < 1) begin : g_bad_cfg
    $error("sw_conditioner: DEB_CNT >= 2, LONG_CNT >= 1 and REP_CNT >= 1 required");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_e;

  logic [N_SW-1:0] sync1_q, sync2_q, pressed;

  // NOTE: sync flops reset to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = (SW_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    state_e            state_q;
    logic [DEB_W-1:0]  deb_q;
    logic [DEB_W-1:0]  deb_d;
    logic [HOLD_W-1:0] hold_q;
    logic              pulse_q, level_q, long_q;
`ifdef SW_REPEAT_EN
    localparam int REP_W = $clog2(REP_CNT + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CNT - 1);
    logic [REP_W-1:0] rep_q;
`endif

    assign deb_d = deb_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        deb_q   <= '0;
        hold_q  <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
        long_q  <= 1'b0;
`ifdef SW_REPEAT_EN
        rep_q   <= '0;
`endif
      end else begin
        // NOTE: default-clear in the clocked block keeps the pulse exactly one cycle wide.
        pulse_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (pressed[i]) begin
              state_q <= PRESS_DEB;
              deb_q   <= '0;
            end
          end
          PRESS_DEB: begin
            if (!pressed[i]) begin
              state_q <= IDLE;
            end else if (deb_d == DEB_LAST) begin
              state_q <= HELD;
              level_q <= 1'b1;
              pulse_q <= 1'b1;
              hold_q  <= '0;
            end else begin
              deb_q <= deb_d;
            end
          end
          HELD: begin
            if (hold_q != LONG_SAT) hold_q <= hold_q + 1'b1;
            if (hold_q >= LONG_LAST) long_q <= 1'b1;
            if (!pressed[i]) begin
              state_q <= REL_DEB;
              deb_q   <= '0;
            end
`ifdef SW_REPEAT_EN
            if (!pressed[i]) begin
              rep_q <= '0;
            end else if (long_q) begin
              if (rep_q == REP_LAST) begin
                rep_q   <= '0;
                pulse_q <= 1'b1;
              end else begin
                rep_q <= rep_q + 1'b1;
              end
            end
`endif
          end
          REL_DEB: begin
            // Release bounce returns to HELD with the hold count intact.
            if (pressed[i]) begin
              state_q <= HELD;
            end else if (deb_d == DEB_LAST) begin
              state_q <= IDLE;
              level_q <= 1'b0;
              long_q  <= 1'b0;
            end else begin
              deb_q <= deb_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign o_sw_pulse[i] = pulse_q;
    assign o_sw_level[i] = level_q;
    assign o_sw_long[i]  = long_q;
  end

endmodule

// File: tb/tb_sw_conditioner.sv
// Scoreboard bench for sw_conditioner: expected pulses are queued at stimulus time and
// matched against the DUT pulse stream; levels and long-press flags are checked at fixed cycles.
module tb_sw_conditioner;

  localparam int N_SW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_SW-1:0] pins = 5'b11111;
  logic [N_SW-1:0] o_sw_pulse, o_sw_level, o_sw_long;

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;

  typedef struct {
    int              cyc;
    logic [N_SW-1:0] mask;
  } exp_t;

  exp_t exp_q[$];

  sw_conditioner #(
    .N_SW(N_SW), .SW_ACTIVE_LOW(1), .DEB_CNT(4), .LONG_CNT(20), .REP_CNT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_sw       (pins),
    .o_sw_pulse (o_sw_pulse),
    .o_sw_level (o_sw_level),
    .o_sw_long  (o_sw_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Sample on the falling edge once the edge counter has reached c.
  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("pulse_missing", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (o_sw_pulse != '0) begin
        if (exp_q.size() == 0) begin
          check("pulse_spurious", 32'(o_sw_pulse), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_cyc", 32'(cyc), 32'(e.cyc));
          check("pulse_mask", 32'(o_sw_pulse), 32'(e.mask));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, r, f, d;

    // Reset with all pins released.
    repeat (3) next_edge();
    @(negedge clk);
    check("rst_pulse", 32'(o_sw_pulse), 32'(0));
    check("rst_level", 32'(o_sw_level), 32'(0));
    check("rst_long",  32'(o_sw_long),  32'(0));
    next_edge();
    rst = 1'b0;
    e = cyc;
    at_cyc(e + 50);
    check("idle_pulse", 32'(o_sw_pulse), 32'(0));
    check("idle_level", 32'(o_sw_level), 32'(0));
    check("idle_long",  32'(o_sw_long),  32'(0));

    // Clean press on sw0: pulse and level exactly 6 cycles after the edge.
    next_edge();
    pins[0] = 1'b0;
    e = cyc;
    exp_q.push_back('{e + 6, 5'b00001});
    at_cyc(e + 5);
    check("sw0_level_early", 32'(o_sw_level), 32'(0));
    at_cyc(e + 6);
    check("sw0_level", 32'(o_sw_level), 32'(5'b00001));
    at_cyc(e + 12);
    next_edge();
    pins[0] = 1'b1;
    r = cyc;
    at_cyc(r + 5);
    check("sw0_rel_early", 32'(o_sw_level), 32'(5'b00001));
    at_cyc(r + 6);
    check("sw0_rel", 32'(o_sw_level), 32'(0));

    // Three-cycle glitch on sw1 is one short of acceptance.
    next_edge();
    pins[1] = 1'b0;
    e = cyc;
    repeat (3) next_edge();
    pins[1] = 1'b1;
    at_cyc(e + 12);
    check("sw1_glitch_level", 32'(o_sw_level), 32'(0));

    // sw2 with a two-cycle high bounce before the final release.
    next_edge();
    pins[2] = 1'b0;
    e = cyc;
    exp_q.push_back('{e + 6, 5'b00100});
    at_cyc(e + 10);
    next_edge();
    pins[2] = 1'b1;
    r = cyc;
    repeat (2) next_edge();
    pins[2] = 1'b0;
    repeat (3) next_edge();
    pins[2] = 1'b1;
    f = cyc;
    at_cyc(r + 6);
    check("sw2_bounce_level", 32'(o_sw_level), 32'(5'b00100));
    at_cyc(f + 5);
    check("sw2_level_hold", 32'(o_sw_level), 32'(5'b00100));
    at_cyc(f + 6);
    check("sw2_level_drop", 32'(o_sw_level), 32'(0));

    // Long press on sw3, held 40 cycles.
    next_edge();
    pins[3] = 1'b0;
    e = cyc;
    exp_q.push_back('{e + 6, 5'b01000});
`ifdef SW_REPEAT_EN
    exp_q.push_back('{e + 34, 5'b01000});
    exp_q.push_back('{e + 42, 5'b01000});
`endif
    at_cyc(e + 25);
    check("sw3_long_early", 32'(o_sw_long), 32'(0));
    at_cyc(e + 26);
    check("sw3_long", 32'(o_sw_long), 32'(5'b01000));
    at_cyc(e + 39);
    next_edge();
    pins[3] = 1'b1;
    at_cyc(e + 45);
    check("sw3_long_hold", 32'(o_sw_long), 32'(5'b01000));
    at_cyc(e + 46);
    check("sw3_long_drop", 32'(o_sw_long), 32'(0));
    check("sw3_level_drop", 32'(o_sw_level), 32'(0));

    // Simultaneous sw0/sw4 press, then asynchronous reset while both are held.
    next_edge();
    pins[0] = 1'b0;
    pins[4] = 1'b0;
    e = cyc;
    exp_q.push_back('{e + 6, 5'b10001});
    at_cyc(e + 6);
    check("dual_level", 32'(o_sw_level), 32'(5'b10001));
    at_cyc(e + 10);
    rst = 1'b1;
    #1;
    check("async_rst_level", 32'(o_sw_level), 32'(0));
    check("async_rst_pulse", 32'(o_sw_pulse), 32'(0));
    repeat (2) next_edge();
    rst = 1'b0;
    d = cyc;
    repeat (2) next_edge();
    pins = 5'b11111;
    at_cyc(d + 15);
    check("post_rst_level", 32'(o_sw_level), 32'(0));
    check("post_rst_long",  32'(o_sw_long),  32'(0));
    check("queue_drained",  32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
